mc14500_sequencer: RTL and testbench
====================================

// Module: mc14500_sequencer
// PURPOSE
//  Program sequencer directly upstream of the MC14500 ICU core. Owns the program counter,
//  fetches 12-bit words {operand,opcode} from external program memory and drives the core's
//  4-bit instruction bus. Consumes the core's JMP/RTN/FLAG_O/FLAG_F outputs to implement
//  jump, call/return and halt. Drives the operand as I/O address for the bit-I/O mux.
// PARAMETERS
//  AW          8  program address width; also operand / jump-target / io_addr width
//  STACK_DEPTH 4  return-stack entries (>=1)
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     asynchronous, active-high reset
//  prog_addr_o  out  AW    program memory address (= PC)
//  prog_data_i  in   AW+4  fetched word, combinational read: [AW+3:4] operand, [3:0] opcode
//  ins_o        out  4     instruction to core I[3:0]
//  io_addr_o    out  AW    operand of the instruction the core is executing
//  jmp_i        in   1     core JMP flag
//  rtn_i        in   1     core RTN flag
//  flag_o_i     in   1     core FLAG_O (NOPO) = halt request
//  flag_f_i     in   1     core FLAG_F (NOPF) = call prefix
//  run_i        in   1     single-cycle pulse: leave halt
//  halted_o     out  1     sequencer halted
//  stk_err_o    out  1     sticky: return-stack overflow/underflow
// BEHAVIOUR
//  Reset: pc=0, halted_o=0, stack empty, stk_err_o=0, io_addr_o=0, iss_v=0, call_arm=0.
//  Issue (comb): ins_o = halted_o ? 4'h0 : prog_data_i[3:0]. prog_addr_o = pc.
//  Core latency fixed at 1: flags seen in cycle n+1 belong to word issued in cycle n.
//  iss_v <= !halted_o; flags are acted on only when iss_v=1 (ignored after reset/in halt).
//  op_q <= prog_data_i operand each non-halted cycle; io_addr_o = op_q (held while halted).
//  Branch delay slot: word at pc+1 after JMP/RTN is always issued (RTN's slot is skipped
//   inside the core). No squashing by this block.
//  Next pc when not halted, priority order:
//   1 jmp_i & iss_v: pc <= op_q. If call_arm: push pc+1 (word after delay slot).
//   2 rtn_i & iss_v: pc <= top, pop.
//   3 else pc <= pc+1, wraps 2^AW-1 -> 0.
//  call_arm <= flag_f_i & iss_v; so call = NOPF immediately followed by JMP.
//  jmp_i & rtn_i together: JMP wins, no pop.
//  Push when full: push dropped, stack unchanged, stk_err_o<=1; jump still taken.
//  Pop when empty: stk_err_o<=1, pc <= pc+1.
//  Halt: flag_o_i & iss_v -> halted_o<=1 next edge; word issued that cycle completes, pc
//   advances past it then holds. Halted: ins_o=NOPO, pc/stack/op_q frozen.
//  run_i while halted: halted_o<=0, fetch resumes at held pc. run_i while running: no-op.
//  run_i and flag_o_i in same cycle: halt wins.
//  States: RUN, HALT (halted_o). Async rst from any state -> RUN, pc=0; stk_err_o cleared
//   only by rst.
// CONFIGURATION
//  MC14500_CALL_STACK_EN defined: return stack, call/return, stk_err_o as above.
//  Undefined: no stack; NOPF+JMP is a plain jump, rtn_i ignored (pc<=pc+1),
//   stk_err_o tied 0, STACK_DEPTH unused.
// TESTING
//  Reset, mem = LD ops: prog_addr_o 0,1,2,... each clk; ins_o=mem opcode; 0xFF -> 0x00 wrap.
//  JMP op=0x40 at 0x10, core jmp_i next cycle: addr seq 0x10,0x11,0x40; stack unchanged.
//  NOPF@0x20, JMP 0x80@0x21, RTN@0x81: seq 0x21,0x22,0x80,0x81,0x82,0x23; io_addr_o=0x80 at JMP exec.
//  5 nested calls, STACK_DEPTH=4: stk_err_o=1 after 5th; 4 returns restore 4 addrs; 5th RTN
//   gives pc+1.
//  NOPO@0x30: halted_o=1 with pc=0x32, ins_o=0 held 10 clk; run_i pulse -> fetch 0x32.
//  rst mid-call while halted: pc=0, halted_o=0, stk_err_o=0; first-cycle flags ignored.

Source files
------------

// File: rtl/mc14500_sequencer.sv
// Program sequencer for the MC14500 ICU: owns the PC, issues fetched opcodes, handles jump/call/return/halt.
// Optional return stack enabled by defining MC14500_CALL_STACK_EN.
module mc14500_sequencer #(
   parameter int unsigned AW          = 8,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   output logic [AW-1:0] prog_addr_o,
   input  logic [AW+3:0] prog_data_i,
   output logic [3:0]    ins_o,
   output logic [AW-1:0] io_addr_o,
   input  logic          jmp_i,
   input  logic          rtn_i,
   input  logic          flag_o_i,
   input  logic          flag_f_i,
   input  logic          run_i,
   output logic          halted_o,
   output logic          stk_err_o
);

   typedef enum logic {RUN, HALT} state_t;

   state_t        state;
   logic [AW-1:0] pc;
   logic [AW-1:0] op_q;
   logic [AW-1:0] pc_inc;
   logic [AW-1:0] pc_nxt;
   logic          iss_v;
   logic          running;
   logic          take_jmp;
   logic          halt_req;

   assign running     = (state == RUN);
   assign halted_o    = (state == HALT);
   assign pc_inc      = pc + AW'(1);
   assign prog_addr_o = pc;
   assign io_addr_o   = op_q;
   assign ins_o       = halted_o ? 4'h0 : prog_data_i[3:0];
   // Core flags belong to the word issued last cycle; only trusted if that issue was real.
   assign take_jmp    = jmp_i & iss_v;
   assign halt_req    = flag_o_i & iss_v;

`ifdef MC14500_CALL_STACK_EN
   localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [AW-1:0]  stk [0:(1<<IW)-1];
   logic [SPW-1:0] sp;
   logic [AW-1:0]  top;
   logic           call_arm;
   logic           err_q;
   logic           take_rtn;
   logic           full;
   logic           empty;
   logic           push;
   logic           pop;
   logic           push_err;
   logic           pop_err;

   // JMP outranks RTN when both are flagged together.
   assign take_rtn  = rtn_i & iss_v & ~jmp_i;
   assign full      = (sp == SPW'(STACK_DEPTH));
   assign empty     = (sp == '0);
   assign top       = stk[IW'(sp - SPW'(1))];
   assign push      = running & take_jmp & call_arm & ~full;
   assign pop       = running & take_rtn & ~empty;
   assign push_err  = running & take_jmp & call_arm & full;
   assign pop_err   = running & take_rtn & empty;
   assign pc_nxt    = take_jmp ? op_q : (pop ? top : pc_inc);
   assign stk_err_o = err_q;

   // Return address is the word after the delay slot, i.e. the slot's pc + 1.
   always_ff @(posedge clk) begin
      if (push) stk[IW'(sp)] <= pc_inc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp       <= '0;
         call_arm <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         call_arm <= flag_f_i & iss_v;
         if (push)     sp <= sp + SPW'(1);
         else if (pop) sp <= sp - SPW'(1);
         if (push_err | pop_err) err_q <= 1'b1;
      end
   end
`else
   logic unused_cfg;

   assign unused_cfg = ^{rtn_i, flag_f_i, 32'(STACK_DEPTH)};
   assign pc_nxt     = take_jmp ? op_q : pc_inc;
   assign stk_err_o  = 1'b0;
`endif

   // Run/halt control; pc and operand register freeze while halted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         pc    <= '0;
         op_q  <= '0;
         iss_v <= 1'b0;
      end else begin
         iss_v <= running;
         if (running) begin
            pc   <= pc_nxt;
            op_q <= prog_data_i[AW+3:4];
            if (halt_req) state <= HALT;
         end else if (run_i && !halt_req) begin
            state <= RUN;
         end
      end
   end

endmodule

// File: tb/tb_mc14500_sequencer.sv
// Directed bench for mc14500_sequencer with a one-cycle-latency core flag model and program ROM.
module tb_mc14500_sequencer;

`ifdef MC14500_CALL_STACK_EN
   localparam bit STK = 1'b1;
`else
   localparam bit STK = 1'b0;
`endif

   localparam logic [3:0] OP_NOPO = 4'h0;
   localparam logic [3:0] OP_LD   = 4'h1;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_RTN  = 4'hD;
   localparam logic [3:0] OP_NOPF = 4'hF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  prog_addr_o;
   logic [11:0] prog_data_i;
   logic [3:0]  ins_o;
   logic [7:0]  io_addr_o;
   logic        jmp_i, rtn_i, flag_o_i, flag_f_i;
   logic        run_i = 1'b0;
   logic        halted_o, stk_err_o;

   logic [11:0] mem [256];
   logic        jmp_m = 1'b0, rtn_m = 1'b0, flo_m = 1'b0, flf_m = 1'b0;
   logic        jmp_f = 1'b0, rtn_f = 1'b0, flo_f = 1'b0;
   logic [7:0]  last_a = 8'h00;
   int          n_vec = 0;
   int          n_err = 0;

   mc14500_sequencer #(.AW(8), .STACK_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .prog_addr_o(prog_addr_o), .prog_data_i(prog_data_i),
      .ins_o(ins_o), .io_addr_o(io_addr_o),
      .jmp_i(jmp_i), .rtn_i(rtn_i), .flag_o_i(flag_o_i), .flag_f_i(flag_f_i),
      .run_i(run_i), .halted_o(halted_o), .stk_err_o(stk_err_o)
   );

   always #5 clk = ~clk;

   assign prog_data_i = mem[prog_addr_o];
   assign jmp_i    = jmp_m | jmp_f;
   assign rtn_i    = rtn_m | rtn_f;
   assign flag_o_i = flo_m | flo_f;
   assign flag_f_i = flf_m;

   // Core stand-in: decodes the issued opcode and raises its flag one cycle later.
   always_ff @(posedge clk) begin
      jmp_m <= (ins_o == OP_JMP);
      rtn_m <= (ins_o == OP_RTN);
      flo_m <= (ins_o == OP_NOPO);
      flf_m <= (ins_o == OP_NOPF);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic load_base();
      for (int a = 0; a < 256; a++) mem[a] = {8'(a * 3 + 7), OP_LD};
   endtask

   task automatic step(input logic [7:0] a);
      @(posedge clk);
      #1;
      jmp_f = 1'b0; rtn_f = 1'b0; flo_f = 1'b0;
      check("pc", 32'(prog_addr_o), 32'(a));
      check("ins", 32'(ins_o), 32'(mem[a][3:0]));
      check("halted", 32'(halted_o), 32'd0);
      check("io", 32'(io_addr_o), 32'(mem[last_a][11:4]));
      last_a = a;
   endtask

   task automatic hstep(input logic [7:0] a);
      @(posedge clk);
      #1;
      check("pc_hold", 32'(prog_addr_o), 32'(a));
      check("ins_nopo", 32'(ins_o), 32'd0);
      check("halted", 32'(halted_o), 32'd1);
      check("io_hold", 32'(io_addr_o), 32'(mem[last_a][11:4]));
   endtask

   task automatic walk(input int from, input int to);
      for (int a = from; a <= to; a++) step(8'(a));
   endtask

   // Reset with garbage flags forced into the first cycle; they must be ignored.
   task automatic do_reset();
      rst = 1'b1;
      jmp_f = 1'b1; rtn_f = 1'b1; flo_f = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_pc", 32'(prog_addr_o), 32'd0);
      check("rst_halted", 32'(halted_o), 32'd0);
      check("rst_stk_err", 32'(stk_err_o), 32'd0);
      check("rst_io", 32'(io_addr_o), 32'd0);
      check("rst_ins", 32'(ins_o), 32'(mem[0][3:0]));
      last_a = 8'h00;
      step(8'h01);
   endtask

   task automatic load_nested();
      load_base();
      mem[8'h50] = {8'h00, OP_NOPF}; mem[8'h51] = {8'h58, OP_JMP};
      mem[8'h58] = {8'h00, OP_NOPF}; mem[8'h59] = {8'h60, OP_JMP};
      mem[8'h60] = {8'h00, OP_NOPF}; mem[8'h61] = {8'h68, OP_JMP};
      mem[8'h68] = {8'h00, OP_NOPF}; mem[8'h69] = {8'h70, OP_JMP};
      mem[8'h70] = {8'h00, OP_NOPF}; mem[8'h71] = {8'h78, OP_JMP};
      mem[8'h78] = {8'h00, OP_RTN};  mem[8'h6B] = {8'h00, OP_RTN};
      mem[8'h63] = {8'h00, OP_RTN};  mem[8'h5B] = {8'h00, OP_RTN};
      mem[8'h53] = {8'h00, OP_RTN};
   endtask

   task automatic nested_calls();
      walk(2, 8'h52); step(8'h58);
      walk(8'h59, 8'h5A); step(8'h60);
      walk(8'h61, 8'h62); step(8'h68);
      walk(8'h69, 8'h6A); step(8'h70);
      check("stk_err_4calls", 32'(stk_err_o), 32'd0);
      walk(8'h71, 8'h72); step(8'h78);
      check("stk_err_5calls", 32'(stk_err_o), 32'(STK));
   endtask

   initial begin
      // Sequential fetch, run_i while running is a no-op, 0xFF -> 0x00 wrap.
      load_base();
      do_reset();
      walk(2, 4);
      run_i = 1'b1;
      step(8'h05);
      run_i = 1'b0;
      walk(6, 255);
      step(8'h00);
      step(8'h01);
      check("stk_err_seq", 32'(stk_err_o), 32'd0);

      // Plain jump with delay slot.
      load_base();
      mem[8'h10] = {8'h40, OP_JMP};
      do_reset();
      walk(2, 8'h11);
      step(8'h40);
      step(8'h41);
      check("stk_err_jmp", 32'(stk_err_o), 32'd0);

      // Call (NOPF + JMP) and return.
      load_base();
      mem[8'h20] = {8'h00, OP_NOPF};
      mem[8'h21] = {8'h80, OP_JMP};
      mem[8'h81] = {8'h00, OP_RTN};
      do_reset();
      walk(2, 8'h22);
      check("io_at_jmp", 32'(io_addr_o), 32'h80);
      step(8'h80); step(8'h81); step(8'h82);
`ifdef MC14500_CALL_STACK_EN
      step(8'h23);
`else
      step(8'h83);
`endif
      check("stk_err_call", 32'(stk_err_o), 32'd0);

      // Five nested calls into a four-deep stack, then five returns.
      load_nested();
      do_reset();
      nested_calls();
      step(8'h79);
`ifdef MC14500_CALL_STACK_EN
      step(8'h6B); step(8'h6C);
      step(8'h63); step(8'h64);
      step(8'h5B); step(8'h5C);
      step(8'h53); step(8'h54);
      step(8'h55);
`else
      walk(8'h7A, 8'h7C);
`endif
      check("stk_err_sticky", 32'(stk_err_o), 32'(STK));

      // Halt on NOPO; a second NOPO beats a simultaneous run_i; run_i resumes at held pc.
      load_base();
      mem[8'h30] = {8'h00, OP_NOPO};
      mem[8'h31] = {8'h00, OP_NOPO};
      do_reset();
      walk(2, 8'h31);
      hstep(8'h32);
      run_i = 1'b1;
      hstep(8'h32);
      run_i = 1'b0;
      repeat (9) hstep(8'h32);
      run_i = 1'b1;
      step(8'h32);
      run_i = 1'b0;
      step(8'h33);
      step(8'h34);

      // Asynchronous reset while halted inside nested calls.
      load_nested();
      mem[8'h78] = {8'h00, OP_NOPO};
      do_reset();
      nested_calls();
      step(8'h79);
      hstep(8'h7A);
      hstep(8'h7A);
      check("stk_err_pre_rst", 32'(stk_err_o), 32'(STK));
      rst = 1'b1;
      #1;
      check("arst_pc", 32'(prog_addr_o), 32'd0);
      check("arst_halted", 32'(halted_o), 32'd0);
      check("arst_stk_err", 32'(stk_err_o), 32'd0);
      do_reset();
      walk(2, 5);
      check("stk_err_post_rst", 32'(stk_err_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
